// File: rtl/mult_hilo_unit.sv
// Iterative radix-2 shift-add multiplier with architectural HI/LO registers.
// Optional macro SIGNED_MULT_EN enables signed multiplies (magnitude convert + final negate).
module mult_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  input  logic             hiWrite,
  input  logic             loWrite,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  // state  | meaning
  // S_IDLE | waiting for start; HI/LO writes commit directly from product
  // S_RUN  | one shift-add iteration per cycle, WIDTH cycles total
  // S_DONE | product valid, done pulse, pending HI/LO writes commit
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2*WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]       r_mplier;
  logic [2*WIDTH-1:0]     r_acc;
  logic [2*WIDTH-1:0]     r_product;
  logic [CW-1:0]          r_count;
  logic                   r_pend_hi;
  logic                   r_pend_lo;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;

  logic                   w_busy;
  logic                   w_done;
  logic                   w_accept;
  logic                   w_last;
  logic [WIDTH-1:0]       w_mag_a;
  logic [WIDTH-1:0]       w_mag_b;
  logic                   w_neg_in;
  logic [2*WIDTH-1:0]     w_acc_step;
  logic [2*WIDTH-1:0]     w_result;

`ifdef SIGNED_MULT_EN
  logic                   r_neg;
  logic                   w_a_neg;
  logic                   w_b_neg;

  assign w_a_neg    = signed_op & a[WIDTH-1];
  assign w_b_neg    = signed_op & b[WIDTH-1];
  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign w_mag_a    = w_a_neg ? -a : a;
  assign w_mag_b    = w_b_neg ? -b : b;
  assign w_neg_in   = w_a_neg ^ w_b_neg;
  assign w_result   = r_neg ? -w_acc_step : w_acc_step;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= w_neg_in;
    end
  end
`else
  logic                   w_unused_signed_op;

  assign w_unused_signed_op = signed_op;
  assign w_mag_a    = a;
  assign w_mag_b    = b;
  assign w_neg_in   = 1'b0;
  assign w_result   = w_acc_step;
`endif

  assign w_last     = (r_count == CW'(1));
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier  <= w_mag_b;
      r_acc     <= '0;
      r_count   <= CW'(WIDTH);
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - CW'(1);
      // Final iteration folds the sign fix-up so product is valid throughout DONE.
      if (w_last) begin
        r_product <= w_result;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= 1'b0;
      r_pend_lo <= 1'b0;
    end else if (w_done) begin
      if (r_pend_hi || hiWrite) begin
        r_hi <= r_product[2*WIDTH-1:WIDTH];
      end
      if (r_pend_lo || loWrite) begin
        r_lo <= r_product[WIDTH-1:0];
      end
      r_pend_hi <= 1'b0;
      r_pend_lo <= 1'b0;
    end else if (w_busy) begin
      if (hiWrite) begin
        r_pend_hi <= 1'b1;
      end
      if (loWrite) begin
        r_pend_lo <= 1'b1;
      end
    end else begin
      if (hiWrite) begin
        r_hi <= r_product[2*WIDTH-1:WIDTH];
      end
      if (loWrite) begin
        r_lo <= r_product[WIDTH-1:0];
      end
    end
  end

  assign busy   = w_busy;
  assign done   = w_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit: directed corner cases plus randomized
// operands compared against a 64-bit arithmetic reference product.
module tb_mult_hilo_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         signed_op;
  logic         hiWrite;
  logic         loWrite;
  logic         busy;
  logic         done;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mult_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .signed_op(signed_op), .hiWrite(hiWrite), .loWrite(loWrite),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // Reference: sign- or zero-extend to 64 bits and multiply modulo 2^64.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
    logic [2*W-1:0] ex;
    logic [2*W-1:0] ey;
    ex = {{W{1'b0}}, x};
    ey = {{W{1'b0}}, y};
`ifdef SIGNED_MULT_EN
    if (s) begin
      ex = {{W{x[W-1]}}, x};
      ey = {{W{y[W-1]}}, y};
    end
`endif
    return ex * ey;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs);
    a = xa; b = xb; signed_op = xs; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                        output int cyc);
    issue(xa, xb, xs);
    wait_done(cyc);
    step();
  endtask

  task automatic commit(input logic h, input logic l);
    hiWrite = h; loWrite = l;
    step();
    hiWrite = 1'b0; loWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; a = '0; b = '0; signed_op = 1'b0;
    hiWrite = 1'b0; loWrite = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (hi_out !== '0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi_out); end
    checks++; if (lo_out !== '0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo_out); end
    reset = 1'b1;
    step();
    commit(1'b1, 1'b1);
    checks++; if ({hi_out, lo_out} !== '0) begin errors++; $display("FAIL reset_product got %h exp 0", {hi_out, lo_out}); end
  endtask

  task automatic test_basic();
    int cyc;
    issue(32'd7, 32'd6, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b exp 1", busy); end
    wait_done(cyc);
    checks++; if (cyc != W) begin errors++; $display("FAIL basic_latency got %0d exp %0d", cyc, W); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got %b exp 1", busy); end
    checks++; if (lo_out !== '0) begin errors++; $display("FAIL basic_no_early_commit got %h exp 0", lo_out); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle got done=%b busy=%b exp 0 0", done, busy); end
    commit(1'b1, 1'b1);
    checks++; if (hi_out !== 32'h0 || lo_out !== 32'h2A) begin errors++; $display("FAIL basic_7x6 got %h_%h exp 00000000_0000002a", hi_out, lo_out); end
    exp_hi = hi_out; exp_lo = lo_out;
  endtask

  task automatic test_unsigned_max();
    int cyc;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc);
    checks++; if (cyc != W) begin errors++; $display("FAIL max_latency got %0d exp %0d", cyc, W); end
    commit(1'b1, 1'b1);
    checks++; if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001) begin errors++; $display("FAIL max_product got %h_%h exp fffffffe_00000001", hi_out, lo_out); end
  endtask

  task automatic test_signed();
    int cyc;
    logic [2*W-1:0] e;
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, cyc);
    commit(1'b1, 1'b1);
`ifdef SIGNED_MULT_EN
    e = 64'hFFFF_FFFF_FFFF_FFF1;
`else
    e = 64'h0000_0004_FFFF_FFF1;
`endif
    checks++; if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL signed_m3x5 got %h exp %h", {hi_out, lo_out}, e); end
    run_op(32'h8000_0000, 32'd3, 1'b1, cyc);
    commit(1'b1, 1'b1);
    e = ref_prod(32'h8000_0000, 32'd3, 1'b1);
    checks++; if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL signed_mostneg got %h exp %h", {hi_out, lo_out}, e); end
    run_op(32'h0, 32'hFFFF_FFFF, 1'b1, cyc);
    checks++; if (cyc != W) begin errors++; $display("FAIL zero_latency got %0d exp %0d", cyc, W); end
    commit(1'b1, 1'b1);
    checks++; if ({hi_out, lo_out} !== '0) begin errors++; $display("FAIL zero_product got %h exp 0", {hi_out, lo_out}); end
    run_op(32'h1234_5678, 32'h8765_4321, 1'b1, cyc);
    commit(1'b1, 1'b1);
    exp_hi = hi_out; exp_lo = lo_out;
  endtask

  task automatic test_pending();
    int cyc;
    issue(32'd2, 32'd3, 1'b0);
    step(); step();
    hiWrite = 1'b1; loWrite = 1'b1;
    step();
    hiWrite = 1'b0; loWrite = 1'b0;
    checks++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin errors++; $display("FAIL pending_hold_run got %h_%h exp %h_%h", hi_out, lo_out, exp_hi, exp_lo); end
    wait_done(cyc);
    checks++; if (cyc != W - 3) begin errors++; $display("FAIL pending_latency got %0d exp %0d", cyc, W - 3); end
    checks++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin errors++; $display("FAIL pending_hold_done got %h_%h exp %h_%h", hi_out, lo_out, exp_hi, exp_lo); end
    step();
    checks++; if (hi_out !== 32'h0 || lo_out !== 32'h6) begin errors++; $display("FAIL pending_commit got %h_%h exp 00000000_00000006", hi_out, lo_out); end
    exp_hi = hi_out; exp_lo = lo_out;
  endtask

  task automatic test_ignored_start();
    int cyc;
    issue(32'd2, 32'd3, 1'b0);
    step(); step(); step();
    a = 32'd9; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b exp 1", busy); end
    wait_done(cyc);
    checks++; if (cyc != W - 4) begin errors++; $display("FAIL ignore_latency got %0d exp %0d", cyc, W - 4); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_requeue got busy=%b exp 0", busy); end
    commit(1'b1, 1'b1);
    checks++; if (hi_out !== 32'h0 || lo_out !== 32'h6) begin errors++; $display("FAIL ignore_result got %h_%h exp 00000000_00000006", hi_out, lo_out); end
  endtask

  task automatic test_hilo_independent();
    int cyc;
    logic [2*W-1:0] e;
    logic [W-1:0] ra, rb;
    ra = $urandom | 32'h0100_0000; rb = $urandom | 32'h0100_0000;
    e = ref_prod(ra, rb, 1'b0);
    run_op(ra, rb, 1'b0, cyc);
    commit(1'b1, 1'b0);
    checks++; if (hi_out !== e[2*W-1:W] || lo_out !== 32'h6) begin errors++; $display("FAIL indep_hi_only got %h_%h exp %h_00000006", hi_out, lo_out, e[2*W-1:W]); end
    commit(1'b0, 1'b1);
    checks++; if (hi_out !== e[2*W-1:W] || lo_out !== e[W-1:0]) begin errors++; $display("FAIL indep_lo_only got %h_%h exp %h", hi_out, lo_out, e); end
  endtask

  task automatic test_random();
    int cyc;
    logic [2*W-1:0] e;
    logic [W-1:0] ra, rb;
    logic rs;
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i == 3) ra = 32'h8000_0000;
      if (i == 4) rb = 32'hFFFF_FFFF;
      e = ref_prod(ra, rb, rs);
      run_op(ra, rb, rs, cyc);
      checks++; if (cyc != W) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, cyc, W); end
      commit(1'b1, 1'b1);
      checks++; if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL rand_product[%0d] a=%h b=%h s=%b got %h exp %h", i, ra, rb, rs, {hi_out, lo_out}, e); end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int seen_done;
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, cyc);
    commit(1'b1, 1'b1);
    issue(32'd5, 32'd5, 1'b0);
    for (int i = 0; i < 8; i++) step();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (hi_out !== '0 || lo_out !== '0) begin errors++; $display("FAIL midrst_hilo got %h_%h exp 0_0", hi_out, lo_out); end
    @(negedge clk);
    reset = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles exp 0", seen_done); end
    commit(1'b1, 1'b1);
    checks++; if ({hi_out, lo_out} !== '0) begin errors++; $display("FAIL midrst_product got %h exp 0", {hi_out, lo_out}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unsigned_max();
    test_signed();
    test_pending();
    test_ignored_start();
    test_hilo_independent();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
